split_sampler: RTL and testbench

SPLIT_SAMPLER -- requirements
Module: split_sampler

---
 rtl/split_sampler_pkg.sv | 24 ++
 rtl/split_sampler_prng.sv | 28 ++
 rtl/split_sampler.sv | 160 ++++++++++++++++
 tb/tb_split_sampler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/split_sampler_pkg.sv
// Shared solver types and helpers: FSM state enum, xorshift32 step, zero-seed substitute.
// Pure declarations; no latency or backpressure of its own.
package split_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    // xorshift32 has an all-zero fixed point, so a zero seed is replaced by this.
    localparam logic [31:0] ZERO_SEED_SUB = 32'h1;

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/split_sampler_prng.sv
// xorshift32 generator: value is the current state, advanced on step, reseeded on load.
// One-cycle update latency; no backpressure (step is a plain enable).
module xorshift32_gen
    import split_sampler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ZERO_SEED_SUB;
        end else if (load) begin
            r_state <= (seed == 32'd0) ? ZERO_SEED_SUB : seed;
        end else if (step) begin
            r_state <= xorshift32_step(r_state);
        end
    end

    assign value = r_state;

endmodule

// File: rtl/split_sampler.sv
// Rejection sampler: draws PRNG candidates until the external checker passes one, NWORDS+1 cycles per try.
// sample is held in HOLD until sample_ready; the PRNG only advances in DRAW, so a stalled consumer stalls everything.
module split_sampler
    import split_sampler_pkg::*;
#(
    parameter int SAMPLE_W  = 35,
    parameter int MAX_TRIES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         seed,
    input  logic [15:0]         count,
    output logic [SAMPLE_W-1:0] cand,
    input  logic                pass,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [15:0]         tries
);

    localparam int          NWORDS    = (SAMPLE_W + 31) / 32;
    localparam int          WCW       = $clog2(NWORDS + 1);
    localparam logic [15:0] TRY_LIMIT = 16'(MAX_TRIES);

    state_t              r_state;
    state_t              w_next_state;
    logic [SAMPLE_W-1:0] r_cand;
    logic [SAMPLE_W-1:0] r_sample;
    logic [15:0]         r_tries;
    logic [15:0]         r_remaining;
    logic [WCW-1:0]      r_word_cnt;
    logic                r_done;

    logic                w_start_ok;
    logic                w_xfer;
    logic                w_last_word;
    logic                w_at_limit;
    logic [31:0]         w_prng_value;
    logic [31:0]         w_new_word;
    logic [SAMPLE_W-1:0] w_cand_shift;

    xorshift32_gen u_prng (
        .clk   (clk),
        .rst   (rst),
        .load  (w_start_ok),
        .seed  (seed),
        .step  (r_state == ST_DRAW),
        .value (w_prng_value)
    );

    assign w_new_word  = xorshift32_step(w_prng_value);
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_FAIL));
    assign w_xfer      = (r_state == ST_HOLD) && sample_ready;
    assign w_last_word = (r_word_cnt == WCW'(NWORDS - 1));
    assign w_at_limit  = ((r_tries + 16'd1) == TRY_LIMIT);

    // Each DRAW word shifts in at the bottom; older words age out of the top.
    generate
        if (SAMPLE_W > 32) begin : g_wide
            assign w_cand_shift = {r_cand[SAMPLE_W-33:0], w_new_word};
        end else begin : g_narrow
            assign w_cand_shift = w_new_word[SAMPLE_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    w_next_state = (count == 16'd0) ? ST_IDLE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (w_last_word) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pass) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = w_at_limit ? ST_FAIL : ST_DRAW;
                end
            end
            ST_HOLD: begin
                if (sample_ready) begin
                    w_next_state = (r_remaining == 16'd1) ? ST_IDLE : ST_DRAW;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != ST_IDLE) && (r_state != ST_FAIL);
        sample_valid = (r_state == ST_HOLD);
        fail         = (r_state == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand      <= '0;
            r_sample    <= '0;
            r_tries     <= 16'd0;
            r_remaining <= 16'd0;
            r_word_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FAIL: begin
                    if (start) begin
                        r_remaining <= count;
                        r_tries     <= 16'd0;
                        r_word_cnt  <= '0;
                        r_done      <= (count == 16'd0);
                    end
                end
                ST_DRAW: begin
                    r_cand     <= w_cand_shift;
                    r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCW'(1);
                end
                ST_CHECK: begin
                    if (pass) begin
                        r_sample <= r_cand;
                    end else if (r_tries != TRY_LIMIT) begin
                        r_tries <= r_tries + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - 16'd1;
                        r_tries     <= 16'd0;
                        r_done      <= (r_remaining == 16'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cand   = r_cand;
    assign sample = r_sample;
    assign tries  = r_tries;
    assign done   = r_done;

endmodule

// File: tb/tb_split_sampler.sv
// Bench for split_sampler: a behavioural checker model drives pass, a reference model predicts samples.
module tb_split_sampler;

    localparam int SW = 35;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   seed;
    logic [15:0]   count;
    logic [SW-1:0] cand;
    logic          pass;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          busy;
    logic          done;
    logic          fail;
    logic [15:0]   tries;

    int            n_checks = 0;
    int            n_pass   = 0;

    logic [1:0]    pass_mode;
    logic [SW-1:0] target;
    logic [31:0]   m_st;

    split_sampler #(.SAMPLE_W(SW), .MAX_TRIES(MT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .count        (count),
        .cand         (cand),
        .pass         (pass),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .tries        (tries)
    );

    always #5 clk = ~clk;

    // Stand-in for the split_NN checker: upper 12-bit field must exceed the middle one.
    function automatic bit m_pred(input logic [SW-1:0] c);
        return c[34:23] > c[22:11];
    endfunction

    assign pass = (pass_mode == 2'd0) ? 1'b1 :
                  (pass_mode == 2'd1) ? 1'b0 :
                  (pass_mode == 2'd2) ? (cand == target) : m_pred(cand);

    function automatic logic [31:0] m_next(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x * 32'd8192);
        y = y ^ (y / 32'd131072);
        y = y ^ (y * 32'd32);
        return y;
    endfunction

    task automatic m_seed(input logic [31:0] s);
        m_st = (s == 32'd0) ? 32'd1 : s;
    endtask

    // One candidate = two consecutive words, first word's low bits on top, truncated to SW.
    task automatic m_draw(output logic [SW-1:0] c);
        logic [63:0] acc;
        m_st = m_next(m_st);
        acc  = {m_st, 32'd0};
        m_st = m_next(m_st);
        acc  = acc | {32'd0, m_st};
        c    = acc[SW-1:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [15:0] c);
        seed  = s;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!sample_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (cand !== '0)      $display("FAIL reset_cand: got %h want 0", cand); else n_pass++;
        n_checks++; if (sample !== '0)    $display("FAIL reset_sample: got %h want 0", sample); else n_pass++;
        n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0)    $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (fail !== 1'b0)    $display("FAIL reset_fail: got %b want 0", fail); else n_pass++;
        n_checks++; if (tries !== 16'd0)  $display("FAIL reset_tries: got %0d want 0", tries); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic(input logic [31:0] s);
        int n;
        pass_mode    = 2'd0;
        sample_ready = 1'b1;
        do_start(s, 16'd1);
        wait_valid(n);
        n_checks++; if (n != 3) $display("FAIL basic_latency seed=%0d: got %0d want 3", s, n); else n_pass++;
        n_checks++; if (cand !== 35'h1_0408_0601) $display("FAIL basic_cand seed=%0d: got %h want 104080601", s, cand); else n_pass++;
        n_checks++; if (sample !== 35'h1_0408_0601) $display("FAIL basic_sample seed=%0d: got %h want 104080601", s, sample); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL basic_early_done seed=%0d: got %b want 0", s, done); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL basic_done seed=%0d: got %b want 1", s, done); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sample_valid !== 1'b0) $display("FAIL basic_idle seed=%0d: busy=%b valid=%b want 0 0", s, busy, sample_valid); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse seed=%0d: got %b want 0", s, done); else n_pass++;
    endtask

    task automatic test_count_zero;
        do_start($urandom, 16'd0);
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_count: done=%b busy=%b want 1 0", done, busy); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL zero_count_pulse: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_reject;
        logic [31:0]   s;
        logic [SW-1:0] c1, c2, c3;
        int            n;
        s = $urandom | 32'h100;
        m_seed(s);
        m_draw(c1);
        m_draw(c2);
        m_draw(c3);
        target       = c3;
        pass_mode    = 2'd2;
        sample_ready = 1'b0;
        do_start(s, 16'd1);
        wait_valid(n);
        n_checks++; if (n != 9) $display("FAIL reject_latency: got %0d want 9", n); else n_pass++;
        n_checks++; if (tries !== 16'd2) $display("FAIL reject_tries: got %0d want 2", tries); else n_pass++;
        n_checks++; if (sample !== c3) $display("FAIL reject_sample: got %h want %h", sample, c3); else n_pass++;
        sample_ready = 1'b1;
        tick();
        n_checks++; if (done !== 1'b1 || tries !== 16'd0) $display("FAIL reject_done: done=%b tries=%0d want 1 0", done, tries); else n_pass++;
    endtask

    task automatic test_fail;
        int n;
        logic [31:0] s;
        s         = $urandom;
        pass_mode = 2'd1;
        do_start(s, 16'd2);
        n = 0;
        while (!fail && n < 100) begin
            tick();
            n++;
        end
        n_checks++; if (n != 12) $display("FAIL fail_latency: got %0d want 12", n); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sample_valid !== 1'b0) $display("FAIL fail_outputs: busy=%b valid=%b want 0 0", busy, sample_valid); else n_pass++;
        n_checks++; if (tries !== 16'd4) $display("FAIL fail_tries: got %0d want 4", tries); else n_pass++;
        tick();
        tick();
        n_checks++; if (fail !== 1'b1 || done !== 1'b0) $display("FAIL fail_sticky: fail=%b done=%b want 1 0", fail, done); else n_pass++;
        pass_mode = 2'd0;
        do_start(s, 16'd1);
        n_checks++; if (fail !== 1'b0 || busy !== 1'b1) $display("FAIL fail_restart: fail=%b busy=%b want 0 1", fail, busy); else n_pass++;
        n_checks++; if (tries !== 16'd0) $display("FAIL fail_restart_tries: got %0d want 0", tries); else n_pass++;
        sample_ready = 1'b1;
        wait_valid(n);
        tick();
    endtask

    task automatic test_back_to_back;
        logic [SW-1:0] e [3];
        logic [SW-1:0] held;
        logic [31:0]   s;
        int            n, k, dones;
        s = $urandom;
        m_seed(s);
        for (int i = 0; i < 3; i++) m_draw(e[i]);
        pass_mode    = 2'd0;
        sample_ready = 1'b0;
        do_start(s, 16'd3);
        wait_valid(n);
        held = sample;
        n_checks++; if (held !== e[0]) $display("FAIL b2b_first: got %h want %h", held, e[0]); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (sample_valid !== 1'b1 || sample !== e[0]) $display("FAIL b2b_stall%0d: valid=%b sample=%h want 1 %h", i, sample_valid, sample, e[0]); else n_pass++;
        end
        sample_ready = 1'b1;
        k     = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (sample_valid) begin
                if (k < 3) begin
                    n_checks++; if (sample !== e[k]) $display("FAIL b2b_sample%0d: got %h want %h", k, sample, e[k]); else n_pass++;
                end
                k++;
            end
            tick();
            if (done) dones++;
        end
        n_checks++; if (k != 3) $display("FAIL b2b_transfers: got %0d want 3", k); else n_pass++;
        n_checks++; if (dones != 1) $display("FAIL b2b_dones: got %0d want 1", dones); else n_pass++;
    endtask

    task automatic test_start_ignored;
        logic [SW-1:0] e;
        logic [31:0]   s;
        int            n;
        s = $urandom;
        m_seed(s);
        m_draw(e);
        pass_mode    = 2'd0;
        sample_ready = 1'b0;
        do_start(s, 16'd1);
        tick();
        do_start(s ^ 32'h5A5A_0001, 16'd5);
        wait_valid(n);
        n_checks++; if (sample !== e) $display("FAIL ignore_sample: got %h want %h", sample, e); else n_pass++;
        sample_ready = 1'b1;
        tick();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL ignore_count: done=%b busy=%b want 1 0", done, busy); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid;
        bit stray;
        pass_mode    = 2'd0;
        sample_ready = 1'b1;
        do_start($urandom, 16'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (cand !== '0 || sample !== '0) $display("FAIL midrst_data: cand=%h sample=%h want 0 0", cand, sample); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || tries !== 16'd0)
            $display("FAIL midrst_ctrl: busy=%b valid=%b done=%b fail=%b tries=%0d want all 0", busy, sample_valid, done, fail, tries); else n_pass++;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || fail || busy) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) $display("FAIL midrst_quiet: got activity=%b want 0", stray); else n_pass++;
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            logic [SW-1:0] qs[$];
            int            qt[$];
            logic [SW-1:0] c;
            logic [31:0]   s;
            int            cnt, t, k;
            bit            exp_fail, saw_done, saw_fail;
            s        = $urandom;
            cnt      = $urandom_range(1, 4);
            exp_fail = 1'b0;
            m_seed(s);
            for (int i = 0; i < cnt && !exp_fail; i++) begin
                t = 0;
                forever begin
                    m_draw(c);
                    if (m_pred(c)) begin
                        qs.push_back(c);
                        qt.push_back(t);
                        break;
                    end
                    t++;
                    if (t == MT) begin
                        exp_fail = 1'b1;
                        break;
                    end
                end
            end
            pass_mode = 2'd3;
            do_start(s, 16'(cnt));
            k        = 0;
            saw_done = 1'b0;
            saw_fail = 1'b0;
            for (int i = 0; i < 600 && !saw_done && !saw_fail; i++) begin
                sample_ready = 1'($urandom_range(0, 1));
                #1;
                if (sample_valid && sample_ready) begin
                    if (k < qs.size()) begin
                        n_checks++; if (sample !== qs[k] || int'(tries) != qt[k])
                            $display("FAIL rand%0d_sample%0d: got %h/%0d want %h/%0d", r, k, sample, tries, qs[k], qt[k]); else n_pass++;
                    end else begin
                        n_checks++; $display("FAIL rand%0d_extra: got transfer %0d want %0d", r, k, qs.size());
                    end
                    k++;
                end
                tick();
                if (done) saw_done = 1'b1;
                if (fail) saw_fail = 1'b1;
            end
            n_checks++; if (k != qs.size()) $display("FAIL rand%0d_count: got %0d want %0d", r, k, qs.size()); else n_pass++;
            n_checks++; if (saw_fail != exp_fail || saw_done == exp_fail)
                $display("FAIL rand%0d_end: done=%b fail=%b want fail=%b", r, saw_done, saw_fail, exp_fail); else n_pass++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        seed         = 32'd0;
        count        = 16'd0;
        sample_ready = 1'b0;
        pass_mode    = 2'd0;
        target       = '0;
        m_st         = 32'd1;
        test_reset();
        test_basic(32'd1);
        test_basic(32'd0);
        test_count_zero();
        test_reject();
        test_fail();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
